// File: rtl/seq_subtractor_cmp_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor/comparator.
package seq_subtractor_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit cycles per operation.
  function automatic int unsigned calc_ndig(input int unsigned w, input int unsigned d);
    return w / d;
  endfunction

  // Digit counter width; a single-digit operation still needs one bit.
  function automatic int unsigned calc_cntw(input int unsigned ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  // Operand width must split evenly into whole digits.
  function automatic bit geometry_ok(input int unsigned w, input int unsigned d);
    return (d >= 1) && (w >= d) && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = a - b - bin, bout set when a borrow is needed.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/ripple_subtractor.sv
// W-bit combinational ripple-borrow subtractor built from 1-bit cells.
module ripple_subtractor #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] bc;

  assign bc[0] = bin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_subtractor_1bit u_fs (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (bc[i]),
      .d    (d[i]),
      .bout (bc[i+1])
    );
  end

  assign bout = bc[W];

endmodule

// File: rtl/seq_subtractor_cmp.sv
// Digit-serial A - B with borrow, signed overflow and lt/eq/gt compare flags.
module seq_subtractor_cmp
  import seq_subtractor_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = calc_cntw(NDIG);

  if (!geometry_ok(WIDTH, DIGIT)) begin : g_bad_geometry
    $error("seq_subtractor_cmp: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr, b_sr, r_sr;
  logic               borrow_q;
  logic [CW-1:0]      cnt_q;
  logic               mode_q;
  logic               a_msb_q, b_msb_q;

  logic [DIGIT-1:0]   dig_d;
  logic               dig_bout;
  logic [WIDTH-1:0]   r_next;
  logic               accept;
  logic               last;
  logic               fin_msb, fin_ovf, fin_eq, fin_lt;

  ripple_subtractor #(.W(DIGIT)) u_sub (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .bin  (borrow_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  assign accept = start && (state_q != RUN);
  assign last   = (state_q == RUN) && (cnt_q == CW'(NDIG - 1));

  // New digit enters at the top; with WIDTH == DIGIT the shift clears r_sr entirely.
  assign r_next = (r_sr >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));

  // Completion flags derived from the final result and captured operand signs.
  always_comb begin
    fin_msb = r_next[WIDTH-1];
    fin_ovf = (a_msb_q != b_msb_q) && (fin_msb != a_msb_q);
    fin_eq  = (r_next == '0);
    fin_lt  = mode_q ? (fin_msb ^ fin_ovf) : dig_bout;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // Operand capture, digit shifting and result registers loaded on the last digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
      lt       <= 1'b0;
      eq       <= 1'b0;
      gt       <= 1'b0;
    end else if (accept) begin
      a_sr     <= a;
      b_sr     <= b;
      r_sr     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= signed_mode;
      a_msb_q  <= a[WIDTH-1];
      b_msb_q  <= b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sr     <= a_sr >> DIGIT;
      b_sr     <= b_sr >> DIGIT;
      r_sr     <= r_next;
      borrow_q <= dig_bout;
      cnt_q    <= cnt_q + CW'(1);
      if (last) begin
        diff <= r_next;
        bout <= dig_bout;
        ovf  <= fin_ovf;
        lt   <= fin_lt;
        eq   <= fin_eq;
        gt   <= ~fin_lt & ~fin_eq;
      end
    end
  end

endmodule

// File: tb/tb_seq_subtractor_cmp.sv
// Directed bench for seq_subtractor_cmp with WIDTH=16, DIGIT=4.
module tb_seq_subtractor_cmp;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        lt;
  logic        eq;
  logic        gt;

  int checks = 0;
  int errors = 0;

  seq_subtractor_cmp #(.WIDTH(16), .DIGIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .diff        (diff),
    .bout        (bout),
    .ovf         (ovf),
    .lt          (lt),
    .eq          (eq),
    .gt          (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] ia, input logic [15:0] ib, input logic sm);
    a = ia;
    b = ib;
    signed_mode = sm;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'h5A5A;
    b = 16'hA5A5;
    signed_mode = ~sm;
  endtask

  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cyc++;
      tick();
      cyc++;
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] ed, input logic eb,
                           input logic eo, input logic elt, input logic eeq, input logic egt);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    chk({tag, "_ovf"},  ovf,  eo);
    chk({tag, "_lt"},   lt,   elt);
    chk({tag, "_eq"},   eq,   eeq);
    chk({tag, "_gt"},   gt,   egt);
  endtask

  task automatic do_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input logic sm, input logic [15:0] ed, input logic eb,
                       input logic eo, input logic elt, input logic eeq, input logic egt);
    int cyc, bcyc;
    launch(ia, ib, sm);
    wait_done(cyc, bcyc);
    chk({tag, "_latency"}, cyc, 4);
    chk({tag, "_busycycles"}, bcyc, 4);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    check_res(tag, ed, eb, eo, elt, eeq, egt);
    tick();
    chk({tag, "_done_pulse"}, done, 1'b0);
    tick();
    chk({tag, "_hold_diff"}, diff, ed);
    chk({tag, "_hold_lt"}, lt, elt);
  endtask

  initial begin
    int cyc, bcyc, npulse;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    check_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    //       tag      a        b        sm    diff     bout ovf  lt   eq   gt
    do_op("u_basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("u_neg",   16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("s_neg",   16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("s_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op("u_ovf",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_op("u_eq",    16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op("s_eq",    16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op("s_povf",  16'h0005, 16'h8000, 1'b1, 16'h8005, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Start during RUN is ignored; original result arrives on schedule.
    launch(16'h1234, 16'h0234, 1'b0);
    tick();
    a = 16'hABCD;
    b = 16'h0000;
    signed_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, bcyc);
    chk("ign_latency", cyc, 2);
    chk("ign_done", done, 1'b1);
    check_res("ign", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back start accepted in the DONE cycle.
    a = 16'h0001;
    b = 16'h0002;
    signed_mode = 1'b0;
    start = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("b2b_busy", busy, 1'b1);
      end
    end while (!done && cyc < 20);
    chk("b2b_gap", cyc, 5);
    check_res("b2b", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();

    // Reset asserted for one edge during the second RUN cycle.
    launch(16'hABCD, 16'h1234, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    check_res("abort", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) npulse++;
    end
    chk("abort_nopulse", npulse, 0);

    do_op("post_rst", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_subtractor_cmp.md
# seq_subtractor_cmp

Parametrised digit-serial subtractor/comparator. It computes A − B over WIDTH bits, processing DIGIT bits per clock and starting from the least-significant digit. On completion it reports the difference, the borrow-out, signed overflow and lt/eq/gt compare flags. It sits where the comparator datapath needs wide operands without a full-width ripple chain, trading latency for area.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits subtracted per clock; must be ≥1.
- Derived: NDIG = WIDTH/DIGIT, the cycles per operation.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  minuend; captured on the accepted start.
- b  in  WIDTH  subtrahend; captured on the accepted start.
- signed_mode  in  1  selects two's-complement compare when 1; captured on the accepted start.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- diff  out  WIDTH  A − B modulo 2^WIDTH.
- bout  out  1  unsigned borrow-out (1 when A < B unsigned).
- ovf  out  1  signed overflow of A − B.
- lt, eq, gt  out  1 each  compare result under the captured mode; exactly one is high after the first completion.

## Operation
- States: IDLE, RUN, DONE (defined in the package).
- IDLE or DONE, start=1:
  - capture a, b and signed_mode into shift registers;
  - clear the borrow register and the digit counter;
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- DONE, start=0: go to IDLE.
- RUN, each cycle:
  - subtract the low DIGIT bits of the a/b shift registers with borrow-in = borrow register;
  - shift the digit difference into the top of the result shift register;
  - update the borrow register;
  - shift the operands right by DIGIT;
  - increment the counter.
- Counter == NDIG−1 in RUN: go to DONE. In the same edge, load the output registers:
  - diff ← final shifted result;
  - bout ← final borrow;
  - ovf ← (a_msb ≠ b_msb) & (diff_msb ≠ a_msb);
  - unsigned mode: lt = bout;
  - signed mode: lt = diff_msb ^ ovf;
  - eq = (diff == 0);
  - gt = ~lt & ~eq.
- Output registers change only at completion. They hold their value through later IDLE/RUN cycles until the next completion.
- start while busy=1 is ignored and has no side effects.
- Operand inputs are don't-care except on the accepted start edge.

## Timing
- Accepted start at edge t:
  - busy=1 for cycles t+1 … t+NDIG;
  - done=1 for exactly one cycle after edge t+NDIG;
  - results are visible in that same cycle.
- Latency: NDIG cycles from the start edge to done.
- Back-to-back throughput: one operation per NDIG+1 cycles, because start is accepted in the DONE cycle.
- done is never high while busy is high.
- NDIG=1 (WIDTH=DIGIT): RUN lasts one cycle and latency is 1.
- rst_n=0 at any edge, including mid-RUN:
  - next state is IDLE and the operation is aborted; no done is produced;
  - busy=0, done=0;
  - diff, bout, ovf, lt, gt = 0 and eq = 0;
  - borrow register and counter are cleared.
- rst_n=0 takes priority over start in the same edge.

## Structure
- Shared package holds:
  - the state enum (IDLE/RUN/DONE);
  - a function computing NDIG and the counter width $clog2(NDIG) (minimum 1);
  - an elaboration check that WIDTH % DIGIT == 0.
- One sub-module, ripple_subtractor #(W):
  - W-bit combinational borrow chain built from full_subtractor_1bit instances;
  - ports: a, b, bin → d, bout;
  - instantiated with W=DIGIT.
- The top level holds the FSM, the counter, the shift registers and the output registers.

## Test plan
All cases use WIDTH=16, DIGIT=4.
- Unsigned 0x1234 − 0x0234 → diff=0x1000, bout=0, gt=1; done exactly 4 cycles after start; busy high for 4 cycles.
- Unsigned 0x0001 − 0x0002 → diff=0xFFFF, bout=1, lt=1. The same operands in signed mode also give lt=1, ovf=0.
- Signed 0x8000 − 0x0001 → diff=0x7FFF, ovf=1, lt=1. The same operands unsigned give gt=1, bout=0.
- 0xABCD − 0xABCD in either mode → diff=0x0000, eq=1, bout=0, ovf=0.
- Start pulsed again during RUN with different operands → ignored; the original result appears at the original done cycle. A new start in the DONE cycle → second done 5 cycles after the first.
- rst_n low for one edge in the 2nd RUN cycle → busy=0 next cycle, no done pulse, all outputs 0. A fresh start afterwards completes normally.
